// File: rtl/clk_wiz_exdes.sv
// Behavioural 1:1 clocking-wizard example: lock sequencer, glitch-free output
// clock gate, synchronized counter-reset and a free-running sampling counter.
module clk_wiz_exdes #(
    parameter int LOCK_CYCLES = 256,
    parameter int C_W         = 16,
    parameter int SYNC_STAGES = 3
) (
    input  logic       clk_in1,
    input  logic       reset,
    input  logic       power_down,
    input  logic       COUNTER_RESET,
    output logic [1:1] CLK_OUT,
    output logic       COUNT,
    output logic       input_clk_stopped,
    output logic       locked
);

    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);
    localparam logic [LW-1:0] LOCK_ARM = LW'(LOCK_CYCLES - 1);

    logic [LW-1:0]          lock_cnt_q, lock_cnt_d;
    logic                   locked_q;
    logic                   stopped_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;
    logic [C_W-1:0]         samp_cnt_q, samp_cnt_d;
    logic                   gate_en_lat;

    assign rst_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (lock_cnt_q != LOCK_MAX)
            lock_cnt_d = lock_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_in1) begin
        if (reset || power_down) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            if (lock_cnt_q == LOCK_ARM)
                locked_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_in1) begin
        if (reset)
            stopped_q <= 1'b0;
        else
            stopped_q <= power_down;
    end

    // COUNTER_RESET arrives from another timing domain; it only enters via this chain.
    always_ff @(posedge clk_in1) begin
        if (reset)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], COUNTER_RESET};
    end

    always_comb begin
        samp_cnt_d = samp_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_in1) begin
        if (reset || !locked_q || rst_sync)
            samp_cnt_q <= '0;
        else
            samp_cnt_q <= samp_cnt_d;
    end

    // Latch is open only while the clock is low, so the gate never changes mid-pulse.
    always_latch begin
        if (!clk_in1)
            gate_en_lat <= locked_q;
    end

    assign CLK_OUT[1]        = clk_in1 & gate_en_lat;
    assign COUNT             = samp_cnt_q[C_W-1];
    assign input_clk_stopped = stopped_q;
    assign locked            = locked_q;

endmodule

// File: tb/tb_clk_wiz_exdes.sv
// Randomized and directed bench for clk_wiz_exdes, checked every cycle against
// a cycle-count based reference model of lock, sync delay and counter rules.
`timescale 1ps/1ps
module tb_clk_wiz_exdes;

    localparam int LOCK_CYCLES = 256;
    localparam int C_W         = 16;
    localparam int SYNC_STAGES = 3;
    localparam int MAXCYC      = 100000;

    logic       clk_in1 = 1'b0;
    logic       reset = 1'b1;
    logic       power_down = 1'b0;
    logic       COUNTER_RESET = 1'b0;
    logic [1:1] CLK_OUT;
    logic       COUNT;
    logic       input_clk_stopped;
    logic       locked;

    int total = 0;
    int bad = 0;

    // Reference model state
    int             t = 0;
    int             last_rst = 0;
    int             run_len = 0;
    bit             crhist [0:MAXCYC-1];
    logic           locked_m = 1'b0;
    logic           stopped_m = 1'b0;
    logic [C_W-1:0] cnt_m = '0;

    clk_wiz_exdes #(
        .LOCK_CYCLES(LOCK_CYCLES),
        .C_W(C_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_in1(clk_in1),
        .reset(reset),
        .power_down(power_down),
        .COUNTER_RESET(COUNTER_RESET),
        .CLK_OUT(CLK_OUT),
        .COUNT(COUNT),
        .input_clk_stopped(input_clk_stopped),
        .locked(locked)
    );

    initial begin
        forever begin
            #1562 clk_in1 = 1'b1;
            #1563 clk_in1 = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs mid-low-phase, advance the model at the edge, compare.
    task automatic step(input logic r, input logic pd, input logic cr);
        logic lp;
        logic rs;
        @(negedge clk_in1);
        reset = r;
        power_down = pd;
        COUNTER_RESET = cr;
        #1 chk("clkout_low", {31'b0, CLK_OUT[1]}, 32'd0);
        @(posedge clk_in1);
        t++;
        lp = locked_m;
        rs = (t - SYNC_STAGES > last_rst) ? crhist[t - SYNC_STAGES] : 1'b0;
        if (r || !lp || rs) cnt_m = '0;
        else                cnt_m = cnt_m + 1'b1;
        if (r || pd) run_len = 0;
        else if (run_len < LOCK_CYCLES) run_len++;
        locked_m  = (run_len >= LOCK_CYCLES);
        stopped_m = r ? 1'b0 : pd;
        crhist[t] = cr;
        if (r) last_rst = t;
        #1;
        chk("locked",    {31'b0, locked},            {31'b0, locked_m});
        chk("stopped",   {31'b0, input_clk_stopped}, {31'b0, stopped_m});
        chk("count_msb", {31'b0, COUNT},             {31'b0, cnt_m[C_W-1]});
        chk("samp_cnt",  {16'b0, dut.samp_cnt_q},    {16'b0, cnt_m});
        chk("clkout_hi", {31'b0, CLK_OUT[1]},        {31'b0, lp});
    endtask

    // Output clock period whenever consecutive pulses are back to back.
    longint last_rise = 0;
    bit     have_rise = 1'b0;
    always @(posedge CLK_OUT[1]) begin
        if (have_rise && ($time - last_rise) < 64'd4000)
            chk("clk_period", 32'($time - last_rise), 32'd3125);
        last_rise = $time;
        have_rise = 1'b1;
    end

    initial begin
        int hold_pd;
        int hold_cr;
        logic cr_v;
        repeat (200) step(1'b1, 1'b0, 1'b0);
        repeat (LOCK_CYCLES + 20) step(1'b0, 1'b0, 1'b0);
        repeat (19) step(1'b0, 1'b0, 1'b1);
        repeat (1024) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (65545) step(1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b0);
        repeat (300) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (100) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (300) step(1'b0, 1'b0, 1'b0);

        hold_pd = 0;
        hold_cr = 0;
        cr_v = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_pd == 0 && $urandom_range(0, 399) == 0) hold_pd = $urandom_range(1, 20);
            if (hold_cr == 0) begin
                hold_cr = $urandom_range(1, 40);
                cr_v = ($urandom_range(0, 3) == 0);
            end
            step(($urandom_range(0, 499) == 0), (hold_pd != 0), cr_v);
            if (hold_pd != 0) hold_pd--;
            hold_cr--;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_wiz_exdes.md
Name: clk_wiz_exdes

Overview:
- Single-output clocking-wizard example design, written as a synthesizable behavioural model of a 1:1 (M/D = 1) clock generator.
- Input clock clk_in1 is nominally 320 MHz (3.125 ns period). The block forwards it as CLK_OUT[1] at the same frequency once "locked".
- It also runs a sampling counter in the output domain and exports the counter's MSB as COUNT.
- Sits at top of the clocking example; drives status (locked, input_clk_stopped) to the bench/system.

Parameters:
- LOCK_CYCLES, 256, clk_in1 rising edges after reset/power_down release before locked asserts (min 2).
- C_W, 16, sampling counter width; COUNT = counter[C_W-1].
- SYNC_STAGES, 3, flop stages synchronizing COUNTER_RESET (min 2).

Ports:
- clk_in1  input  1  sole clock; every register is clocked on its rising edge.
- reset  input  1  synchronous, active-high reset of the whole block.
- power_down  input  1  active-high; behaves like a held reset of the lock logic.
- COUNTER_RESET  input  1  active-high request to clear the sampling counter; asynchronous to the counter, so it is synchronized.
- CLK_OUT  output  [1:1]  generated clock, same period and phase as clk_in1 while enabled, low otherwise.
- COUNT  output  1  MSB of the sampling counter.
- input_clk_stopped  output  1  high while the input path is powered down.
- locked  output  1  high when CLK_OUT[1] is valid.

Behaviour:
- Clock and reset: one clock (clk_in1); reset is synchronous and active-high. No asynchronous resets anywhere.
- Reset values (reset=1 at a rising edge):
  - locked=0, input_clk_stopped=0.
  - lock counter=0, sync chain all 0, sampling counter=0, so COUNT=0.
  - Gate enable=0, so CLK_OUT[1]=0.
- Lock sequencer:
  - Counter lock_cnt, width clog2(LOCK_CYCLES+1).
  - While reset or power_down: lock_cnt=0 and locked=0.
  - Otherwise lock_cnt increments each edge, saturating at LOCK_CYCLES.
  - locked is registered: locked<=1 on the edge where lock_cnt==LOCK_CYCLES-1. It is therefore high exactly LOCK_CYCLES edges after the first edge with reset=0 and power_down=0.
  - power_down or reset mid-lock or while locked: locked drops on the next edge, and the full relock sequence restarts after release.
- input_clk_stopped: registered copy of power_down (1-cycle latency); cleared by reset.
- Output clock gating:
  - CLK_OUT[1] = clk_in1 AND gate_en_lat.
  - gate_en_lat is a transparent-low latch of locked: it updates only while clk_in1 is low.
  - Consequence: no runt pulses. The first CLK_OUT pulse is the first full high phase after locked rises, and the last pulse is complete before gating stops.
  - Output period equals the input period (3125 ps); jitter from the model is 0.
- Counter-reset synchronizer: SYNC_STAGES-flop shift chain of COUNTER_RESET; rst_sync = last stage.
- Sampling counter:
  - Register of width C_W on the clk_in1 rising edge.
  - Clears when reset=1, or locked=0, or rst_sync=1.
  - Otherwise increments by 1 each edge (modelling the count of CLK_OUT rising edges).
  - Wraps modulo 2^C_W: all-ones goes to 0 with no flag.
- Simultaneous events: reset dominates everything. rst_sync=1 beats increment. A COUNTER_RESET pulse shorter than one clock period is not guaranteed to be captured.

Test Plan:
- Hold reset=1 for 200 cycles -> locked=0, COUNT=0, CLK_OUT[1] constantly 0, input_clk_stopped=0.
- Release reset -> locked rises exactly 256 cycles later. First CLK_OUT[1] rising edge comes at the next clk_in1 rising edge, with no partial pulse. Measured CLK_OUT period is 3125 ps (±100 ps).
- 20 cycles after lock, pulse COUNTER_RESET high for ~19 cycles, then run 1024 cycles -> counter=0 for 3 cycles after rise through 3 cycles after fall. Afterwards it increments by 1 per cycle (≈1024 after 1024 cycles) and COUNT stays 0.
- Run locked for 32768 cycles after a counter reset -> COUNT goes to 1 on the edge where counter reaches 0x8000. After 65536 cycles the counter wraps to 0 and COUNT returns to 0.
- Assert power_down for 10 cycles while locked:
  - locked falls next edge; input_clk_stopped rises next edge.
  - CLK_OUT stops after its current high phase; counter is held at 0.
  - On release, input_clk_stopped falls next edge and locked returns 256 cycles later.
- Assert reset for 1 cycle at lock_cnt=100 -> lock_cnt restarts, and locked rises 256 cycles after reset deassertion.
